divider: RTL and testbench

Multi-cycle 32-bit integer divider for the CPU execute stage (DIV/DIVU). It uses a radix-2 restoring algorithm with one quotient bit per clock. A single-cycle start pulse launches an operation. A single-cycle done pulse reports completion. Quotient and remainder stay registered until the next operation completes.

---
 rtl/divider.sv | 129 ++++++++++++
 tb/tb_divider.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// 33 clocks from the start edge to the done pulse.
module divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dvz_q, dvz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    // The settled partial remainder is always below the divisor, so 32 bits of
    // storage suffice; the 33-bit width only exists across the shift/subtract.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvz_d   = dvz_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;

        shifted = {prem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    qneg_d  = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = signed_div & dividend[WIDTH-1];
                    dvd_d   = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvs_d   = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
                    dvz_d   = (divisor == '0);
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Quotient bits shift into the dividend register as its MSBs are consumed.
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // Divide by zero yields an all-ones quotient; negating the remainder
                // magnitude by the dividend sign restores the original dividend.
                quo_d   = (qneg_q && !dvz_q) ? -dvd_q : dvd_q;
                rem_d   = rneg_q ? -prem_q : prem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the multi-cycle divider.
`timescale 1ns/1ps
module tb_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks;
    int errors;

    divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one divide and return #1 after the edge where done rises (lat = -1 if never).
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        signed_div = ~sd;
        dividend   = 32'hA5A5_5A5A;
        divisor    = 32'h0000_0003;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL reset: done=%b q=%h r=%h required 0/0/0", done, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat;
        run_div(1'b0, 32'h0000_0200, 32'h0000_0100, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL u_latency: got %0d required 33", lat);
        end
        checks++;
        if (quotient !== 32'h2 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL u_200_100: q=%h r=%h required 00000002/00000000", quotient, remainder);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle after pulse, required 0", done);
        end

        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
            errors++;
            $display("FAIL u_ffff_1: lat=%0d q=%h r=%h required 33/ffffffff/00000000",
                     lat, quotient, remainder);
        end

        run_div(1'b0, 32'h8000_0001, 32'h0000_0002, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'h4000_0000 || remainder !== 32'h1) begin
            errors++;
            $display("FAIL u_8001_2: lat=%0d q=%h r=%h required 33/40000000/00000001",
                     lat, quotient, remainder);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || quotient !== 32'h4000_0000 || remainder !== 32'h1) begin
                errors++;
                $display("FAIL u_hold[%0d]: done=%b q=%h r=%h required 0/40000000/00000001",
                         i, done, quotient, remainder);
            end
        end
    endtask

    task automatic test_signed();
        int lat;
        run_div(1'b1, 32'h0000_0200, 32'hFFFF_FF00, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFE || remainder !== 32'h0) begin
            errors++;
            $display("FAIL s_pos_neg: lat=%0d q=%h r=%h required 33/fffffffe/00000000",
                     lat, quotient, remainder);
        end
        run_div(1'b1, 32'hFFFF_FE00, 32'hFFFF_FF00, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'h0000_0002 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL s_neg_neg: lat=%0d q=%h r=%h required 33/00000002/00000000",
                     lat, quotient, remainder);
        end
        run_div(1'b1, 32'hFFFF_FE00, 32'h0000_0100, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFE || remainder !== 32'h0) begin
            errors++;
            $display("FAIL s_neg_pos: lat=%0d q=%h r=%h required 33/fffffffe/00000000",
                     lat, quotient, remainder);
        end
        run_div(1'b1, 32'hEEBA_EBE7, 32'hE67E_F001, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'h0 || remainder !== 32'hEEBA_EBE7) begin
            errors++;
            $display("FAIL s_small_quot: lat=%0d q=%h r=%h required 33/00000000/eebaebe7",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_corner();
        int lat;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'h8000_0000 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL s_overflow: lat=%0d q=%h r=%h required 33/80000000/00000000",
                     lat, quotient, remainder);
        end
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL s_neg7_2: lat=%0d q=%h r=%h required 33/fffffffd/ffffffff",
                     lat, quotient, remainder);
        end
        run_div(1'b0, 32'h1234_5678, 32'h0, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
            errors++;
            $display("FAIL u_div0: lat=%0d q=%h r=%h required 33/ffffffff/12345678",
                     lat, quotient, remainder);
        end
        run_div(1'b1, 32'h1234_5678, 32'h0, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
            errors++;
            $display("FAIL s_div0: lat=%0d q=%h r=%h required 33/ffffffff/12345678",
                     lat, quotient, remainder);
        end
        run_div(1'b1, 32'h8765_4321, 32'h0, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h8765_4321) begin
            errors++;
            $display("FAIL s_div0_neg: lat=%0d q=%h r=%h required 33/ffffffff/87654321",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_restart_ignored();
        int lat;
        // Previous result is 0xFFFFFFFF / 0x87654321 and must not move while busy.
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'h0000_0064;
        divisor    = 32'h0000_0007;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                start      = 1'b1;
                signed_div = 1'b1;
                dividend   = 32'h0000_1000;
                divisor    = 32'h0000_0010;
            end else begin
                start = 1'b0;
            end
            if (i == 20) begin
                checks++;
                if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h8765_4321) begin
                    errors++;
                    $display("FAIL busy_hold: q=%h r=%h required ffffffff/87654321",
                             quotient, remainder);
                end
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL restart_ignored: lat=%0d q=%h r=%h required 33/0000000e/00000002",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'h0000_0100;
        divisor    = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || quotient !== 32'h0 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: done_pulses=%0d q=%h r=%h required 0/00000000/00000000",
                     seen, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_div(1'b0, 32'h0000_03E8, 32'h0000_0007, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'd142 || remainder !== 32'd6) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d q=%h r=%h required 33/0000008e/00000006",
                     lat, quotient, remainder);
        end
        // Next start is driven while done is still high.
        run_div(1'b1, 32'hFFFF_FF9C, 32'h0000_0007, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d q=%h r=%h required 33/fffffff2/fffffffe",
                     lat, quotient, remainder);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;

        test_reset();
        test_unsigned();
        test_signed();
        test_corner();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
